// File: rtl/ble_pkt_deframer.sv
// BLE packet deframer: access-address search, PDU de-whitening, byte assembly and CRC-24 check.
// Latency: byte_valid one clk after the 8th bit of a byte; pkt_start one clk after the AA-completing bit;
// pkt_end/crc_ok/len_err one clk after the final CRC bit (or the length byte on abort).
// Backpressure: none; the block follows the CDR symbol strobe and has no ready input.
//
// Ports: clk/resetn (async active-low); en forces IDLE; demod_symbol/demod_symbol_clk/preamble_detected
// from the CDR; channel seeds the de-whitener; byte_data/byte_valid carry the header, length and
// payload bytes; pkt_start/pkt_end/crc_ok/len_err/pkt_len report packet status; busy = not IDLE.
// Optional feature macro: DEFRAMER_AA_ERRTOL_EN (access address match tolerates one bit error).
module ble_pkt_deframer #(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter logic [23:0] CRC_INIT    = 24'h555555,
  parameter int unsigned MAX_LEN     = 37,
  parameter int unsigned AA_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       demod_symbol,
  input  logic       demod_symbol_clk,
  input  logic       preamble_detected,
  input  logic [5:0] channel,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       crc_ok,
  output logic       len_err,
  output logic [7:0] pkt_len,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [7:0] AA_TO_LAST = 8'(AA_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_AA, S_HDR, S_PAY, S_CRC, S_DONE, S_ABORT} state_t;

  state_t      state_q, state_d;
  logic        sclk_q, pre_q;
  logic [31:0] aa_q, aa_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [10:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]  lfsr_q, lfsr_d;
  logic [23:0] crc_q, crc_d;
  logic        crc_err_q, crc_err_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        pkt_start_q, pkt_start_d;
  logic [7:0]  pkt_len_q, pkt_len_d;

  // Strobe and preamble edge detection; a disabled block ignores strobes entirely.
  logic        sym_stb, adv, pre_rise;
  logic        din, crc_fb, aa_hit, pay_last;
  logic [31:0] aa_shift;
  logic [7:0]  new_byte;
  logic [6:0]  lfsr_step;
  logic [23:0] crc_step;

  assign sym_stb   = demod_symbol_clk & ~sclk_q;
  assign adv       = sym_stb & en;
  assign pre_rise  = preamble_detected & ~pre_q;
  assign din       = demod_symbol ^ lfsr_q[0];
  assign aa_shift  = {demod_symbol, aa_q[31:1]};
  assign new_byte  = {din, sr_q[7:1]};
  assign lfsr_step = {lfsr_q[0], lfsr_q[6:5], lfsr_q[4] ^ lfsr_q[0], lfsr_q[3:1]};
  assign crc_fb    = crc_q[23] ^ din;
  assign crc_step  = {crc_q[22:0], 1'b0} ^ (crc_fb ? 24'h00065B : 24'h000000);
  // PAYLOAD is only entered with pkt_len >= 1, so 8*len-1 = {len-1, 3'b111}.
  assign pay_last  = (bit_cnt_q == {pkt_len_q - 8'd1, 3'b111});

`ifdef DEFRAMER_AA_ERRTOL_EN
  logic [31:0] aa_diff;
  logic [5:0]  aa_dist;
  always_comb begin
    aa_diff = aa_shift ^ ACCESS_ADDR;
    aa_dist = '0;
    for (int i = 0; i < 32; i++) aa_dist = aa_dist + {5'd0, aa_diff[i]};
    aa_hit = (aa_dist <= 6'd1);
  end
`else
  assign aa_hit = (aa_shift == ACCESS_ADDR);
`endif

  // State register and datapath flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      sclk_q       <= 1'b0;
      pre_q        <= 1'b0;
      aa_q         <= '0;
      to_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      lfsr_q       <= '0;
      crc_q        <= '0;
      crc_err_q    <= 1'b0;
      sr_q         <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      sclk_q       <= demod_symbol_clk;
      pre_q        <= preamble_detected;
      aa_q         <= aa_d;
      to_cnt_q     <= to_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      lfsr_q       <= lfsr_d;
      crc_q        <= crc_d;
      crc_err_q    <= crc_err_d;
      sr_q         <= sr_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      pkt_start_q  <= pkt_start_d;
      pkt_len_q    <= pkt_len_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (pre_rise) state_d = S_AA;
        S_AA: begin
          if (adv) begin
            if (aa_hit)                     state_d = S_HDR;
            else if (to_cnt_q == AA_TO_LAST) state_d = S_IDLE;
          end
        end
        S_HDR: begin
          if (adv && bit_cnt_q == 11'd15) begin
            if (new_byte == 8'd0)           state_d = S_CRC;
            else if (new_byte > MAX_LEN_B)  state_d = S_ABORT;
            else                            state_d = S_PAY;
          end
        end
        S_PAY:   if (adv && pay_last) state_d = S_CRC;
        S_CRC:   if (adv && bit_cnt_q[4:0] == 5'd23) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        S_ABORT: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath updates; everything advances only on an enabled symbol strobe.
  always_comb begin
    aa_d         = aa_q;
    to_cnt_d     = to_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    lfsr_d       = lfsr_q;
    crc_d        = crc_q;
    crc_err_d    = crc_err_q;
    sr_d         = sr_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    pkt_start_d  = 1'b0;
    pkt_len_d    = pkt_len_q;
    case (state_q)
      S_IDLE: begin
        if (pre_rise) begin
          aa_d     = '0;
          to_cnt_d = '0;
        end
      end
      S_AA: begin
        if (adv) begin
          aa_d     = aa_shift;
          to_cnt_d = to_cnt_q + 8'd1;
          if (aa_hit) begin
            pkt_start_d = 1'b1;
            lfsr_d      = {1'b1, channel};
            crc_d       = CRC_INIT;
            crc_err_d   = 1'b0;
            bit_cnt_d   = '0;
            sr_d        = '0;
          end
        end
      end
      S_HDR, S_PAY: begin
        if (adv) begin
          lfsr_d    = lfsr_step;
          crc_d     = crc_step;
          sr_d      = new_byte;
          bit_cnt_d = bit_cnt_q + 11'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = new_byte;
          end
          if (state_q == S_HDR && bit_cnt_q == 11'd15) begin
            pkt_len_d = new_byte;
            bit_cnt_d = '0;
          end
          if (state_q == S_PAY && pay_last) bit_cnt_d = '0;
        end
      end
      S_CRC: begin
        // CRC register is frozen; received bits are compared MSB first.
        if (adv) begin
          lfsr_d    = lfsr_step;
          bit_cnt_d = bit_cnt_q + 11'd1;
          if (din != crc_q[5'd23 - bit_cnt_q[4:0]]) crc_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    pkt_end = (state_q == S_DONE) || (state_q == S_ABORT);
    crc_ok  = (state_q == S_DONE) && !crc_err_q;
    len_err = (state_q == S_ABORT);
    busy    = (state_q != S_IDLE);
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign pkt_start  = pkt_start_q;
  assign pkt_len    = pkt_len_q;

endmodule

// File: tb/tb_ble_pkt_deframer.sv
module tb_ble_pkt_deframer;
  localparam logic [31:0] AA   = 32'h8E89BED6;
  localparam logic [23:0] CRCI = 24'h555555;
  localparam logic [7:0]  MAXL = 8'd37;

  logic       clk = 1'b0;
  logic       resetn, en, demod_symbol, demod_symbol_clk, preamble_detected;
  logic [5:0] channel;
  logic [7:0] byte_data, pkt_len;
  logic       byte_valid, pkt_start, pkt_end, crc_ok, len_err, busy;

  always #5 clk = ~clk;

  ble_pkt_deframer dut (
    .clk(clk), .resetn(resetn), .en(en), .demod_symbol(demod_symbol),
    .demod_symbol_clk(demod_symbol_clk), .preamble_detected(preamble_detected),
    .channel(channel), .byte_data(byte_data), .byte_valid(byte_valid),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .crc_ok(crc_ok), .len_err(len_err),
    .pkt_len(pkt_len), .busy(busy)
  );

  int checks = 0, failures = 0;
  int n_start = 0, n_end = 0;
  logic [7:0] rx_q[$];
  logic       last_crc_ok, last_len_err, busy_after_end, prev_end = 1'b0;
  logic [7:0] last_pkt_len;
  bit         tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];

  // Observe outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (prev_end) busy_after_end = busy;
    prev_end = pkt_end;
    if (byte_valid) rx_q.push_back(byte_data);
    if (pkt_start) n_start++;
    if (pkt_end) begin
      n_end++;
      last_crc_ok  = crc_ok;
      last_len_err = len_err;
      last_pkt_len = pkt_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: AA, then whitened PDU + CRC-24, all LSB first.
  task automatic build_pkt(input logic [5:0] ch, input logic [7:0] hdr, input logic [7:0] len,
                           input bit flip_crc, input int flip_aa);
    bit pb[$];
    logic [23:0] crc;
    logic [6:0]  lf;
    logic [7:0]  by;
    bit b, fb;
    int n_pdu;
    tx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      b = AA[i];
      if (i == flip_aa) b = ~b;
      tx_q.push_back(b);
    end
    exp_q.push_back(hdr);
    exp_q.push_back(len);
    if (len <= MAXL) for (int i = 0; i < int'(len); i++) exp_q.push_back(pay_q[i]);
    for (int j = 0; j < exp_q.size(); j++) begin
      by = exp_q[j];
      for (int i = 0; i < 8; i++) pb.push_back(by[i]);
    end
    n_pdu = pb.size();
    crc = CRCI;
    for (int i = 0; i < n_pdu; i++) begin
      fb  = crc[23] ^ pb[i];
      crc = {crc[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
    end
    for (int k = 0; k < 24; k++) begin
      b = crc[23-k];
      if (flip_crc && k == 5) b = ~b;
      pb.push_back(b);
    end
    lf = {1'b1, ch};
    for (int i = 0; i < pb.size(); i++) begin
      tx_q.push_back(pb[i] ^ lf[0]);
      lf = {lf[0], lf[6:5], lf[4] ^ lf[0], lf[3:1]};
    end
  endtask

  // Called aligned to a falling edge; returns aligned to a falling edge.
  task automatic send_bit(input bit b);
    demod_symbol     = b;
    demod_symbol_clk = 1'b1;
    repeat (2) @(negedge clk);
    demod_symbol_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic preamble_up();
    @(negedge clk);
    preamble_detected = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic preamble_down();
    repeat (4) @(negedge clk);
    preamble_detected = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_pkt(input string tag, input logic [5:0] ch, input logic [7:0] hdr,
                         input logic [7:0] len, input bit flip_crc);
    int st0, en0, rx0, nb;
    channel = ch;
    build_pkt(ch, hdr, len, flip_crc, -1);
    st0 = n_start; en0 = n_end; rx0 = rx_q.size();
    preamble_up();
    foreach (tx_q[i]) send_bit(tx_q[i]);
    preamble_down();
    nb = rx_q.size() - rx0;
    chk({tag, "_start"}, 32'(n_start - st0), 32'd1);
    chk({tag, "_end"}, 32'(n_end - en0), 32'd1);
    chk({tag, "_nbytes"}, 32'(nb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < nb; i++)
      chk({tag, "_byte"}, 32'(rx_q[rx0 + i]), 32'(exp_q[i]));
    chk({tag, "_crc_ok"}, 32'(last_crc_ok), 32'(!flip_crc && len <= MAXL));
    chk({tag, "_len_err"}, 32'(last_len_err), 32'(len > MAXL));
    chk({tag, "_pkt_len"}, 32'(last_pkt_len), 32'(len));
    chk({tag, "_busy_after_end"}, 32'(busy_after_end), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int st0, en0, rx0;
    logic [7:0] rlen;
    resetn = 1'b0; en = 1'b1; demod_symbol = 1'b0; demod_symbol_clk = 1'b0;
    preamble_detected = 1'b0; channel = 6'd37;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({byte_data, byte_valid, pkt_start, pkt_end, crc_ok, len_err, pkt_len, busy}), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Reference ADV packet, then same with a corrupted CRC bit, then oversize length.
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_pkt("adv_ch37", 6'd37, 8'h40, 8'd6, 1'b0);
    run_pkt("adv_badcrc", 6'd37, 8'h40, 8'd6, 1'b1);
    run_pkt("len48_abort", 6'd38, 8'h40, 8'h30, 1'b0);

    // Length boundaries: zero, MAX_LEN, MAX_LEN+1.
    pay_q.delete();
    for (int i = 0; i < 40; i++) pay_q.push_back(8'($urandom));
    run_pkt("len0", 6'd39, 8'h42, 8'd0, 1'b0);
    run_pkt("len37", 6'd37, 8'h46, 8'd37, 1'b0);
    run_pkt("len38", 6'd38, 8'h46, 8'd38, 1'b0);

    // Randomized packets.
    for (int p = 0; p < 6; p++) begin
      pay_q.delete();
      for (int i = 0; i < 40; i++) pay_q.push_back(8'($urandom));
      rlen = 8'($urandom_range(0, 38));
      run_pkt("rand", 6'(37 + $urandom_range(0, 2)), 8'($urandom), rlen, ($urandom_range(0, 3) == 0));
    end

    // No access address within the timeout window.
    st0 = n_start; en0 = n_end;
    preamble_up();
    for (int i = 0; i < 63; i++) send_bit(1'($urandom));
    chk("timeout_busy_63", 32'(busy), 32'd1);
    send_bit(1'($urandom));
    chk("timeout_busy_64", 32'(busy), 32'd0);
    chk("timeout_no_start", 32'(n_start - st0), 32'd0);
    chk("timeout_no_end", 32'(n_end - en0), 32'd0);
    preamble_down();

    // Access address with bit 5 flipped.
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    channel = 6'd37;
    build_pkt(6'd37, 8'h40, 8'd6, 1'b0, 5);
    st0 = n_start; en0 = n_end; rx0 = rx_q.size();
    preamble_up();
    foreach (tx_q[i]) send_bit(tx_q[i]);
    preamble_down();
`ifdef DEFRAMER_AA_ERRTOL_EN
    chk("aa_err_start", 32'(n_start - st0), 32'd1);
    chk("aa_err_end", 32'(n_end - en0), 32'd1);
    chk("aa_err_crc_ok", 32'(last_crc_ok), 32'd1);
    chk("aa_err_nbytes", 32'(rx_q.size() - rx0), 32'd8);
`else
    chk("aa_err_start", 32'(n_start - st0), 32'd0);
    chk("aa_err_end", 32'(n_end - en0), 32'd0);
    chk("aa_err_nbytes", 32'(rx_q.size() - rx0), 32'd0);
`endif
    chk("aa_err_busy", 32'(busy), 32'd0);

    // Reset asserted in the middle of the payload.
    build_pkt(6'd38, 8'h40, 8'd6, 1'b0, -1);
    channel = 6'd38;
    st0 = n_start; en0 = n_end;
    preamble_up();
    for (int i = 0; i < 32 + 16 + 10; i++) send_bit(tx_q[i]);
    resetn = 1'b0;
    preamble_detected = 1'b0;
    #1;
    chk("midpkt_reset_outputs", 32'({byte_data, byte_valid, pkt_start, pkt_end, crc_ok, len_err, pkt_len, busy}), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("midpkt_reset_started", 32'(n_start - st0), 32'd1);
    chk("midpkt_reset_no_end", 32'(n_end - en0), 32'd0);
    chk("midpkt_reset_busy", 32'(busy), 32'd0);

    // Enable dropped during the header of a second packet.
    st0 = n_start; en0 = n_end;
    preamble_up();
    for (int i = 0; i < 32 + 5; i++) send_bit(tx_q[i]);
    chk("en_drop_busy_before", 32'(busy), 32'd1);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("en_drop_busy_next", 32'(busy), 32'd0);
    chk("en_drop_pkt_end", 32'(pkt_end), 32'd0);
    @(negedge clk);
    en = 1'b1;
    preamble_down();
    chk("en_drop_started", 32'(n_start - st0), 32'd1);
    chk("en_drop_no_end", 32'(n_end - en0), 32'd0);

    // Normal operation resumes afterwards.
    run_pkt("after_recover", 6'd39, 8'h40, 8'd6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ble_pkt_deframer.md
Name: ble_pkt_deframer

Overview:
- Downstream of the CDR core (ble_cdr); consumes its recovered bit stream and preamble flag.
- Finds the advertising access address, then de-whitens the PDU and assembles it into bytes.
- Checks the CRC-24 and reports packet boundaries and status.
- Drives the byte/status interface toward the digital back end or the debug outputs of the top wrapper.

Parameters:
- ACCESS_ADDR, 32'h8E89BED6, access address to match (BLE advertising AA, LSB received first).
- CRC_INIT, 24'h555555, CRC register preset (advertising).
- MAX_LEN, 37, largest accepted payload length in bytes; larger lengths abort.
- AA_TIMEOUT, 64, number of symbols after preamble_detected rises within which the AA must match.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous assert, active-low; all state cleared
- en  in  1  block enable; low forces IDLE on the next cycle
- demod_symbol  in  1  recovered bit from CDR
- demod_symbol_clk  in  1  CDR symbol strobe, level signal; each rising edge (sampled in clk) presents one new demod_symbol
- preamble_detected  in  1  CDR preamble flag, level
- channel  in  6  BLE channel index (37/38/39); seeds the de-whitener
- byte_data  out  8  de-whitened PDU byte (header, length, payload), LSB = first bit received
- byte_valid  out  1  one-cycle strobe qualifying byte_data
- pkt_start  out  1  one-cycle pulse on AA match
- pkt_end  out  1  one-cycle pulse when a packet finishes or aborts
- crc_ok  out  1  valid with pkt_end; 1 = CRC matched
- len_err  out  1  valid with pkt_end; 1 = length > MAX_LEN
- pkt_len  out  8  length field of the current packet; held until the next pkt_start
- busy  out  1  high in every state except IDLE

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; internal shift registers 0.

Symbol strobe:
- sym_stb = demod_symbol_clk registered, rising edge detected inside the block.
- demod_symbol is captured in the same cycle that sym_stb is asserted.
- All bit processing advances only on sym_stb.

FSM states and transitions:
- IDLE: on a rising edge of preamble_detected with en=1 → AA_SEARCH. Clear the 32-bit AA shift register and the timeout counter.
- AA_SEARCH: each sym_stb shifts the bit into the AA register from the MSB side (LSB-first order) and increments the timeout counter.
  - If the register equals ACCESS_ADDR → HDR and assert pkt_start on the following cycle.
  - If the counter reaches AA_TIMEOUT with no match → IDLE. No pkt_end is issued.
- HDR: 16 PDU bits (byte 0 = PDU header, byte 1 = length).
  - On the 16th bit, latch pkt_len.
  - If pkt_len = 0 → CRC. If pkt_len > MAX_LEN → ABORT. Otherwise → PAYLOAD.
- PAYLOAD: 8·pkt_len bits; after the last bit → CRC.
- CRC: 24 bits, each compared against the expected CRC bit; any mismatch sets a sticky error. After the 24th bit → DONE.
- DONE: one cycle; pkt_end=1, crc_ok = no mismatch, len_err=0 → IDLE.
- ABORT: one cycle; pkt_end=1, crc_ok=0, len_err=1 → IDLE.

De-whitening:
- 7-bit LFSR x^7+x^4+1, seeded at AA match with {1'b1, channel}, where bit 6 is the position-0 seed bit.
- Output bit w = lfsr[0]. Every PDU and CRC bit is XORed with w.
- The LFSR advances once per sym_stb: lfsr ← {lfsr[0], lfsr[6:5], lfsr[4]^lfsr[0], lfsr[3:1]}.

CRC:
- Register preset to CRC_INIT at AA match.
- For each de-whitened PDU bit d (header and payload only): fb = crc[23]^d; crc ← {crc[22:0],1'b0} ^ (fb ? 24'h00065B : 0).
- In CRC state, received de-whitened bit k (k=0..23) is compared against crc[23-k]; the register is frozen during this state.

Byte assembly:
- Bits shift in LSB-first. byte_valid pulses for one clk on the cycle after the 8th bit of each byte.
- Covers header bytes and payload bytes; CRC bytes are not emitted.

Boundaries and simultaneous events:
- en low in any state → IDLE the next cycle, with no pkt_end. resetn low mid-packet → immediate clear.
- preamble_detected rising while busy is ignored.
- sym_stb arriving in the same cycle as the DONE/ABORT pulse is dropped.
- Back-to-back packets require a new preamble rise.

Optional Feature:
- Macro DEFRAMER_AA_ERRTOL_EN.
- When defined: AA_SEARCH matches when the Hamming distance between the AA register and ACCESS_ADDR is ≤1. Compute it with a popcount over the XOR; the match must still be registered in one cycle.
- When undefined: exact equality only.
- The rest of the behaviour is identical in both cases.

Test Plan:
- Whitened ADV packet on ch37, header 0x40, length 6, payload 01 02 03 04 05 06, valid CRC → pkt_start; 8 byte_valid strobes with data 40 06 01..06; pkt_end with crc_ok=1, len_err=0, pkt_len=6.
- Same packet with a single CRC bit flipped → pkt_end with crc_ok=0; byte stream unchanged.
- Length field 0x30 (48 > 37) → after 2 byte_valid strobes, pkt_end with len_err=1, crc_ok=0; busy low the next cycle.
- Preamble followed by 64 random symbols with no AA → no pkt_start, no pkt_end, busy returns to 0 after the 64th strobe.
- AA with bit 5 flipped → no match without the macro; pkt_start with DEFRAMER_AA_ERRTOL_EN defined.
- resetn pulsed low during PAYLOAD, then en toggled low during HDR of a second packet → all outputs 0 immediately / IDLE next cycle, with no pkt_end in either case.
